// File: rtl/barrel_shift_left_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_left_pipe_if
// Description : Operand/result handshake bundle for barrel_shift_left_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface barrel_shift_left_pipe_if #(
  parameter int WIDTH = 8
);
  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   ctrl;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in, ctrl, in_valid, out_ready,
    input  in_ready, out, out_valid
  );

  modport slave (
    input  in, ctrl, in_valid, out_ready,
    output in_ready, out, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/barrel_shift_left_pipe.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_left_pipe
// Description : Pipelined left barrel shifter, one stage per ctrl bit (MSB
//               first), valid/ready on both sides. Define
//               BARREL_SHIFT_LEFT_ROTATE_EN to rotate instead of zero-fill.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_left_pipe #(
  parameter int WIDTH = 8
) (
  input  wire logic               clk,
  input  wire logic               rst,
  barrel_shift_left_pipe_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int LAST = SHW - 1;

  logic [WIDTH-1:0] r_data  [SHW];
  logic [SHW-1:0]   r_ctrl  [SHW];
  logic [SHW-1:0]   r_valid;

  logic [WIDTH-1:0] w_src   [SHW];
  logic [SHW-1:0]   w_csrc  [SHW];
  logic [SHW-1:0]   w_vsrc;
  logic [WIDTH-1:0] w_dnext [SHW];
  logic [SHW-1:0]   w_rdy;

  function automatic logic [WIDTH-1:0] f_shl(input logic [WIDTH-1:0] d, input int sh);
`ifdef BARREL_SHIFT_LEFT_ROTATE_EN
    return (d << sh) | (d >> (WIDTH - sh));
`else
    return d << sh;
`endif
  endfunction

  // A stage may load when it is empty or everything downstream can move.
  always_comb begin : p_ready
    logic acc;
    w_rdy = '0;
    acc   = bus.out_ready;
    for (int k = LAST; k >= 0; k--) begin
      acc      = acc | ~r_valid[k];
      w_rdy[k] = acc;
    end
  end

  always_comb begin : p_stage_in
    w_src[0]  = bus.in;
    w_csrc[0] = bus.ctrl;
    w_vsrc    = '0;
    w_vsrc[0] = bus.in_valid;
    for (int k = 1; k < SHW; k++) begin
      w_src[k]  = r_data[k-1];
      w_csrc[k] = r_ctrl[k-1];
      w_vsrc[k] = r_valid[k-1];
    end
    for (int k = 0; k < SHW; k++) begin
      w_dnext[k] = w_src[k];
      if (w_csrc[k][LAST-k]) begin
        w_dnext[k] = f_shl(w_src[k], 1 << (LAST - k));
      end
    end
    // Output register reads zero whenever it holds no valid word.
    if (!w_vsrc[LAST]) begin
      w_dnext[LAST] = '0;
    end
  end

  always_ff @(posedge clk) begin : p_pipe
    if (rst) begin
      r_valid <= '0;
      for (int k = 0; k < SHW; k++) begin
        r_data[k] <= '0;
        r_ctrl[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SHW; k++) begin
        if (w_rdy[k]) begin
          r_valid[k] <= w_vsrc[k];
          r_ctrl[k]  <= w_csrc[k];
          r_data[k]  <= w_dnext[k];
        end
      end
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out       = r_data[LAST];
  assign bus.out_valid = r_valid[LAST];

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_left_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shift_left_pipe
// Description : Scoreboard bench for barrel_shift_left_pipe (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_left_pipe;
  localparam int WIDTH = 8;
`ifdef BARREL_SHIFT_LEFT_ROTATE_EN
  localparam logic [7:0] E_T1 = 8'hAD, E_FE7 = 8'h7F, E_W1 = 8'h03, E_W4 = 8'h03;
`else
  localparam logic [7:0] E_T1 = 8'hA8, E_FE7 = 8'h00, E_W1 = 8'h02, E_W4 = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  barrel_shift_left_pipe_if #(.WIDTH(WIDTH)) bus ();
  barrel_shift_left_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         in_waits = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_exp;
  bit         toggle_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] c);
`ifdef BARREL_SHIFT_LEFT_ROTATE_EN
    logic [15:0] dd;
    dd = {d, d} << c;
    return dd[15:8];
`else
    return d << c;
`endif
  endfunction

  // Present one word at posedge+1 and hold it until the handshake completes.
  task automatic send(input logic [7:0] d, input logic [2:0] c, input logic [7:0] e);
    int w;
    bus.in       = d;
    bus.ctrl     = c;
    cur_exp      = e;
    bus.in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      w++;
      @(negedge clk);
    end
    in_waits += w;
    if (w >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic latency_check(input string name, input logic [7:0] e);
    int lat;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_out"}, bus.out, e);
    @(negedge clk);
    check({name, "_one_cycle"}, bus.out_valid, 0);
  endtask

  // Record every accepted word's expected result.
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready) exp_q.push_back(cur_exp);
  end

  // Monitor: scoreboard pops, stall stability, zero output when idle.
  logic       prev_stall = 1'b0;
  logic       prev_rst   = 1'b1;
  logic [7:0] prev_out   = '0;
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (prev_stall && !prev_rst) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_data", bus.out, prev_out);
      end
      if (!bus.out_valid) check("idle_out_zero", bus.out, 0);
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %0h, required no output", bus.out);
        end else begin
          check("scoreboard_data", bus.out, exp_q.pop_front());
        end
      end
    end
    prev_stall <= bus.out_valid && !bus.out_ready;
    prev_out   <= bus.out;
    prev_rst   <= rst;
  end

  always @(posedge clk) begin
    #1;
    if (toggle_en) bus.out_ready = 1'($urandom_range(1, 0));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [2:0] c;
    int         waits0;
    bus.in        = '0;
    bus.ctrl      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cur_exp       = '0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out", bus.out, 0);
    check("reset_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // T1 single word
    send(8'hB5, 3'd3, E_T1);
    latency_check("t1", E_T1);
    @(posedge clk);
    #1;

    // T2 boundaries
    send(8'h5A, 3'd0, 8'h5A);
    send(8'h01, 3'd7, 8'h80);
    send(8'hFE, 3'd7, E_FE7);
    drain();

    // T3 full-rate streaming
    waits0 = in_waits;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          d = 8'($urandom);
          c = 3'($urandom);
          send(d, c, model(d, c));
        end
      end
      begin
        int cnt;
        cnt = 0;
        for (int i = 0; i < 60 && !bus.out_valid; i++) @(negedge clk);
        while (bus.out_valid && cnt < 40) begin
          cnt++;
          @(negedge clk);
        end
        check("t3_burst_len", cnt, 16);
      end
    join
    check("t3_in_ready_stalls", in_waits - waits0, 0);
    drain();

    // T4 back-pressure
    bus.out_ready = 1'b0;
    send(8'h81, 3'd1, E_W1);
    send(8'h0F, 3'd4, 8'hF0);
    send(8'h33, 3'd2, 8'hCC);
    bus.in       = 8'hC0;
    bus.ctrl     = 3'd2;
    cur_exp      = E_W4;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_full_in_ready", bus.in_ready, 0);
      check("t4_hold_out", bus.out, E_W1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("t4_accept_on_drain", bus.in_ready, 1);
    check("t4_drain_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    // T5 reset mid-flight
    send(8'h11, 3'd1, 8'h22);
    send(8'h22, 3'd2, 8'h88);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_in_ready", bus.in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      check("t5_no_valid", bus.out_valid, 0);
      check("t5_out_zero", bus.out, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    send(8'hB5, 3'd3, E_T1);
    latency_check("t5", E_T1);
    @(posedge clk);
    #1;

    // T6 random gaps and back-pressure
    toggle_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(1, 0) == 1) begin
        bus.in   = 8'($urandom);
        bus.ctrl = 3'($urandom);
        @(posedge clk);
        #1;
      end
      d = 8'($urandom);
      c = 3'($urandom);
      send(d, c, model(d, c));
    end
    toggle_en = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
